// File: rtl/apb_mem_arbiter.sv
// apb_mem_arbiter: round-robin arbiter sequencing N_REQ requesters onto one APB slave with a PREADY watchdog
module apb_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]  req_strb,
    output logic [N_REQ-1:0]           req_done,
    output logic [DATA_W-1:0]          req_rdata,
    output logic                       req_err,
    output logic                       PSELx,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    output logic [DATA_W/8-1:0]        PSTRB,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);
    localparam int SW = DATA_W / 8;
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d, last_grant_q, last_grant_d, pick;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [SW-1:0]     pstrb_q, pstrb_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d, found;

    // Scan downward so the requester closest after last_grant is the one left in pick.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant_q) + k) % N_REQ]) begin
                pick  = GW'((int'(last_grant_q) + k) % N_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        done_d       = done_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d  = pick;
                pwrite_d = req_write[pick];
                paddr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                pwdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
                pstrb_d  = req_strb[int'(pick)*SW +: SW];
                psel_d   = 1'b1;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY || (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1))) begin
                    rdata_d         = (PREADY && !pwrite_q) ? PRDATA : '0;
                    err_d           = PREADY ? PSLVERR : 1'b1;
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    done_d          = '0;
                    done_d[grant_q] = 1'b1;
                    last_grant_d    = grant_q;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign req_done  = done_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
endmodule

// File: tb/tb_apb_mem_arbiter.sv
// tb_apb_mem_arbiter: directed checks of arbitration, APB sequencing, wait states, timeout and reset
module tb_apb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NR = 4;
    localparam int TO = 16;
    localparam int SW = DW / 8;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NR-1:0]    req_valid, req_write, req_done;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_strb;
    logic [DW-1:0]    req_rdata, PWDATA, PRDATA;
    logic             req_err, PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]    PADDR;
    logic [SW-1:0]    PSTRB;
    int               checks = 0;
    int               errors = 0;

    always #5 PCLK = ~PCLK;

    apb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_done(req_done),
        .req_rdata(req_rdata), .req_err(req_err), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic tick;
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_strb[i*SW +: SW]   = s;
    endtask

    task automatic test_reset;
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        checks++; if ({PSELx, PENABLE, PWRITE, req_err, req_done} !== 8'h0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {PSELx, PENABLE, PWRITE, req_err, req_done}); end
        checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h exp 0", PADDR); end
        checks++; if (PWDATA !== 64'h0) begin errors++; $display("FAIL reset_pwdata got %h exp 0", PWDATA); end
        checks++; if (PSTRB !== 8'h0) begin errors++; $display("FAIL reset_pstrb got %h exp 0", PSTRB); end
        checks++; if (req_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", req_rdata); end
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h100 + 32'(i) * 32'h10, '0, '0);
        PREADY = 1'b1; PRDATA = 64'h77;
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h100 + 32'(t % 4) * 32'h10) begin
                errors++; $display("FAIL rr_setup t=%0d got sel=%b en=%b addr=%h exp sel=1 en=0 addr=%h", t, PSELx, PENABLE, PADDR, 32'h100 + 32'(t % 4) * 32'h10);
            end
            tick();
            tick();
            checks++; if (req_done !== 4'(1 << (t % 4))) begin errors++; $display("FAIL rr_done t=%0d got %b exp %b", t, req_done, 4'(1 << (t % 4))); end
            if (t == 4) req_valid = '0;
            tick();
        end
    endtask

    task automatic test_write_read;
        set_req(0, 1'b1, 32'h10, 64'hDEADBEEF_01234567, 8'hFF);
        PREADY = 1'b0; PRDATA = 64'h5555;
        req_valid = 4'b0001;
        tick();
        checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PADDR !== 32'h10) begin
            errors++; $display("FAIL wr_setup got sel=%b en=%b wr=%b addr=%h exp 1 0 1 10", PSELx, PENABLE, PWRITE, PADDR);
        end
        checks++; if (PWDATA !== 64'hDEADBEEF_01234567 || PSTRB !== 8'hFF) begin errors++; $display("FAIL wr_data got %h/%h exp deadbeef01234567/ff", PWDATA, PSTRB); end
        PREADY = 1'b1;
        tick();
        checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL wr_access got sel=%b en=%b exp 1 1", PSELx, PENABLE); end
        tick();
        checks++; if (req_done !== 4'b0001 || req_err !== 1'b0 || req_rdata !== 64'h0 || PSELx !== 1'b0) begin
            errors++; $display("FAIL wr_done got done=%b err=%b rdata=%h sel=%b exp 0001 0 0 0", req_done, req_err, req_rdata, PSELx);
        end
        req_valid = '0;
        tick();
        checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL wr_done_pulse got %b exp 0", req_done); end
        set_req(0, 1'b0, 32'h10, '0, '0);
        PRDATA = 64'hDEADBEEF_01234567;
        req_valid = 4'b0001;
        tick();
        checks++; if (PWRITE !== 1'b0 || PADDR !== 32'h10) begin errors++; $display("FAIL rd_setup got wr=%b addr=%h exp 0 10", PWRITE, PADDR); end
        tick();
        tick();
        checks++; if (req_done !== 4'b0001 || req_err !== 1'b0 || req_rdata !== 64'hDEADBEEF_01234567) begin
            errors++; $display("FAIL rd_done got done=%b err=%b rdata=%h exp 0001 0 deadbeef01234567", req_done, req_err, req_rdata);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wait_error;
        set_req(1, 1'b1, 32'h40, 64'h1111_2222_3333_4444, 8'h3C);
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 64'h9999;
        req_valid = 4'b0010;
        tick();
        checks++; if (PSELx !== 1'b1 || PADDR !== 32'h40) begin errors++; $display("FAIL we_setup got sel=%b addr=%h exp 1 40", PSELx, PADDR); end
        for (int c = 2; c <= 7; c++) begin
            tick();
            checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 32'h40 || PWDATA !== 64'h1111_2222_3333_4444 || PSTRB !== 8'h3C || req_done !== 4'b0) begin
                errors++; $display("FAIL we_wait c=%0d got sel=%b en=%b addr=%h done=%b exp 1 1 40 0000", c, PSELx, PENABLE, PADDR, req_done);
            end
        end
        PREADY = 1'b1;
        tick();
        checks++; if (req_done !== 4'b0010 || req_err !== 1'b1 || PSELx !== 1'b0 || PENABLE !== 1'b0) begin
            errors++; $display("FAIL we_done got done=%b err=%b sel=%b en=%b exp 0010 1 0 0", req_done, req_err, PSELx, PENABLE);
        end
        req_valid = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int n;
        set_req(2, 1'b0, 32'h80, '0, '0);
        PREADY = 1'b0; PRDATA = 64'hFFFF_FFFF_FFFF_FFFF;
        req_valid = 4'b0100;
        n = 0;
        for (int c = 0; c < 40 && req_done === 4'b0; c++) begin
            tick();
            if (req_done === 4'b0 && PENABLE === 1'b1) n++;
        end
        checks++; if (n !== TO) begin errors++; $display("FAIL to_access_cycles got %0d exp %0d", n, TO); end
        checks++; if (req_done !== 4'b0100 || req_err !== 1'b1 || req_rdata !== 64'h0) begin
            errors++; $display("FAIL to_done got done=%b err=%b rdata=%h exp 0100 1 0", req_done, req_err, req_rdata);
        end
        req_valid = '0;
        tick();
        set_req(2, 1'b0, 32'h88, '0, '0);
        PRDATA = 64'h1234;
        req_valid = 4'b0100;
        tick();
        checks++; if (PSELx !== 1'b1 || PADDR !== 32'h88) begin errors++; $display("FAIL to_next_setup got sel=%b addr=%h exp 1 88", PSELx, PADDR); end
        repeat (16) tick();
        checks++; if (req_done !== 4'b0 || PENABLE !== 1'b1) begin errors++; $display("FAIL to_edge_pending got done=%b en=%b exp 0000 1", req_done, PENABLE); end
        PREADY = 1'b1;
        tick();
        checks++; if (req_done !== 4'b0100 || req_err !== 1'b0 || req_rdata !== 64'h1234) begin
            errors++; $display("FAIL to_edge_ready got done=%b err=%b rdata=%h exp 0100 0 1234", req_done, req_err, req_rdata);
        end
        req_valid = '0; PREADY = 1'b0;
        tick();
    endtask

    task automatic test_late_request;
        set_req(0, 1'b0, 32'h10, '0, '0);
        set_req(1, 1'b0, 32'h20, '0, '0);
        PRDATA = 64'h42;
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = 4'b0011;
        tick();
        checks++; if (PSELx !== 1'b1 || PADDR !== 32'h10 || req_done !== 4'b0) begin
            errors++; $display("FAIL late_hold got sel=%b addr=%h done=%b exp 1 10 0000", PSELx, PADDR, req_done);
        end
        PREADY = 1'b1;
        tick();
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL late_first_done got %b exp 0001", req_done); end
        req_valid = 4'b0010; PREADY = 1'b0;
        tick();
        tick();
        checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h20) begin
            errors++; $display("FAIL late_grant got sel=%b en=%b addr=%h exp 1 0 20", PSELx, PENABLE, PADDR);
        end
        PREADY = 1'b1;
        tick();
        tick();
        checks++; if (req_done !== 4'b0010) begin errors++; $display("FAIL late_second_done got %b exp 0010", req_done); end
        req_valid = '0; PREADY = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        set_req(3, 1'b1, 32'h30, 64'hAA, 8'h0F);
        set_req(0, 1'b0, 32'h14, '0, '0);
        PREADY = 1'b0;
        req_valid = 4'b1000;
        tick(); tick(); tick();
        checks++; if (PSELx !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 32'h30) begin
            errors++; $display("FAIL rm_pre got sel=%b en=%b addr=%h exp 1 1 30", PSELx, PENABLE, PADDR);
        end
        PRESET = 1'b1;
        #1;
        checks++; if ({PSELx, PENABLE, PWRITE, req_err, req_done} !== 8'h0 || PADDR !== 32'h0 || PWDATA !== 64'h0 || PSTRB !== 8'h0 || req_rdata !== 64'h0) begin
            errors++; $display("FAIL rm_async got ctrl=%b addr=%h wdata=%h strb=%h exp all 0", {PSELx, PENABLE, PWRITE, req_err, req_done}, PADDR, PWDATA, PSTRB);
        end
        req_valid = 4'b1001;
        PREADY = 1'b1;
        tick();
        checks++; if (req_done !== 4'b0 || PSELx !== 1'b0) begin errors++; $display("FAIL rm_held got done=%b sel=%b exp 0000 0", req_done, PSELx); end
        PRESET = 1'b0;
        tick();
        checks++; if (PSELx !== 1'b1 || PADDR !== 32'h14) begin errors++; $display("FAIL rm_first_grant got sel=%b addr=%h exp 1 14", PSELx, PADDR); end
        tick();
        tick();
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL rm_done got %b exp 0001", req_done); end
        req_valid = '0; PREADY = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_wait_error();
        test_timeout();
        test_late_request();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
